// File: rtl/mac_rx.sv
// mac_rx - RMII receive MAC.
//
// Registers the RMII pins, strips preamble/SFD, streams payload dibits out on
// a valid-only stream and holds the trailing 16 FCS dibits back in a delay
// line so they are never emitted. The CRC-32 (bzip2 flavour: poly 04C11DB7,
// init FFFFFFFF, no reflection, final complement) is accumulated over each
// dibit bit 1 first. The FCS is expected as the complemented CRC, most
// significant dibit first. Per-frame status is reported with frame_done/frame_ok.
//
// Ports:
//   clk         in   system clock (50 MHz RMII reference)
//   reset       in   synchronous, active-high reset
//   phy_crsdv   in   RMII carrier sense / data valid
//   phy_rxd     in   RMII receive dibit [1:0]
//   axi_valid   out  axi_dout holds a payload dibit this cycle
//   axi_dout    out  payload dibit [1:0], wire order
//   frame_done  out  one-cycle pulse at the end of every frame that passed SFD
//   frame_ok    out  qualified by frame_done: CRC, length and alignment good
//   stat_good/stat_bad/stat_drop  out [15:0]  only when MAC_RX_STATS_EN is defined
//
// Stream handshake: valid-only. The consumer must take axi_dout in every cycle
// axi_valid=1; there is no ready and no backpressure. Payload of a bad frame
// has already been emitted, so the consumer discards it when frame_ok=0.
//
// Optional feature macro: MAC_RX_STATS_EN (frame/drop statistics counters).

module mac_rx #(
    parameter int MIN_PREAMBLE_DIBITS = 8,
    parameter int MIN_DATA_DIBITS     = 184,
    parameter int MAX_FRAME_DIBITS    = 6072,
    parameter int CRC_DIBITS          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phy_crsdv,
    input  logic [1:0]  phy_rxd,
    output logic        axi_valid,
    output logic [1:0]  axi_dout,
    output logic        frame_done,
    output logic        frame_ok
`ifdef MAC_RX_STATS_EN
    ,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad,
    output logic [15:0] stat_drop
`endif
);

    localparam int DCNT_W = $clog2(MAX_FRAME_DIBITS + 1);
    localparam int PCNT_W = $clog2(MIN_PREAMBLE_DIBITS + 1) + 1;
    localparam int CHK_W  = $clog2(CRC_DIBITS);
    localparam int LAST   = CRC_DIBITS - 1;

    localparam logic [DCNT_W-1:0] MAX_CNT   = DCNT_W'(MAX_FRAME_DIBITS);
    localparam logic [DCNT_W-1:0] CRC_CNT   = DCNT_W'(CRC_DIBITS);
    localparam logic [DCNT_W-1:0] MIN_TOTAL = DCNT_W'(MIN_DATA_DIBITS + CRC_DIBITS);
    localparam logic [PCNT_W-1:0] MIN_PRE   = PCNT_W'(MIN_PREAMBLE_DIBITS);
    localparam logic [CHK_W-1:0]  CHK_LAST  = CHK_W'(CRC_DIBITS - 1);
    localparam logic [31:0]       CRC_POLY  = 32'h04C1_1DB7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_CHECK,
        S_DROP
    } state_t;

    // Two CRC-32 steps, bit 1 of the dibit first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 1; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic                crsdv_q, crsdv_d;
    logic [1:0]          rxd_q, rxd_d;
    logic [PCNT_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [DCNT_W-1:0]   data_cnt_q, data_cnt_d;
    logic [CHK_W-1:0]    chk_cnt_q, chk_cnt_d;
    logic                err_q, err_d;
    logic [31:0]         crc_q, crc_d;
    logic [1:0]          dline_q [CRC_DIBITS];
    logic [1:0]          dline_d [CRC_DIBITS];
    logic                axi_valid_q, axi_valid_d;
    logic [1:0]          axi_dout_q, axi_dout_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_ok_q, frame_ok_d;
    logic                mismatch;

    always_comb begin
        crsdv_d      = phy_crsdv;
        rxd_d        = phy_rxd;
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        data_cnt_d   = data_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        err_d        = err_q;
        crc_d        = crc_q;
        dline_d      = dline_q;
        axi_valid_d  = 1'b0;
        axi_dout_d   = axi_dout_q;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        // In CHECK the CRC register is drained two bits per cycle; its
        // complemented top dibit is what the FCS dibit must equal.
        mismatch     = (dline_q[LAST] != ~crc_q[31:30]);

        case (state_q)
            S_IDLE: begin
                if (crsdv_q) begin
                    if (rxd_q == 2'b01) begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = PCNT_W'(1);
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end

            S_PREAMBLE: begin
                if (!crsdv_q) begin
                    state_d = S_IDLE;
                end else begin
                    case (rxd_q)
                        2'b01: begin
                            if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + PCNT_W'(1);
                        end
                        2'b11: begin
                            if (pre_cnt_q >= MIN_PRE) begin
                                state_d    = S_DATA;
                                crc_d      = '1;
                                data_cnt_d = '0;
                                err_d      = 1'b0;
                            end else begin
                                state_d = S_DROP;
                            end
                        end
                        default: state_d = S_DROP;
                    endcase
                end
            end

            S_DATA: begin
                if (crsdv_q) begin
                    if (data_cnt_q == MAX_CNT) begin
                        // Over-length: the offending dibit is not shifted, so
                        // nothing is emitted alongside frame_done.
                        frame_done_d = 1'b1;
                        state_d      = S_DROP;
                    end else begin
                        dline_d[0] = rxd_q;
                        for (int i = 1; i < CRC_DIBITS; i++) dline_d[i] = dline_q[i-1];
                        data_cnt_d = data_cnt_q + DCNT_W'(1);
                        if (data_cnt_q >= CRC_CNT) begin
                            axi_valid_d = 1'b1;
                            axi_dout_d  = dline_q[LAST];
                            crc_d       = crc_step(crc_q, dline_q[LAST]);
                        end
                    end
                end else if (data_cnt_q < CRC_CNT) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d   = S_CHECK;
                    chk_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end

            S_CHECK: begin
                dline_d[0] = 2'b00;
                for (int i = 1; i < CRC_DIBITS; i++) dline_d[i] = dline_q[i-1];
                crc_d     = {crc_q[29:0], 2'b11};
                chk_cnt_d = chk_cnt_q + CHK_W'(1);
                if (mismatch) err_d = 1'b1;
                if (chk_cnt_q == CHK_LAST) begin
                    frame_done_d = 1'b1;
                    frame_ok_d   = !(err_q || mismatch) && (data_cnt_q >= MIN_TOTAL)
                                   && (data_cnt_q[1:0] == 2'b00);
                    state_d      = S_IDLE;
                end
            end

            S_DROP: begin
                if (!crsdv_q) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            crsdv_q      <= 1'b0;
            rxd_q        <= 2'b00;
            pre_cnt_q    <= '0;
            data_cnt_q   <= '0;
            chk_cnt_q    <= '0;
            err_q        <= 1'b0;
            crc_q        <= '0;
            dline_q      <= '{default: 2'b00};
            axi_valid_q  <= 1'b0;
            axi_dout_q   <= 2'b00;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            crsdv_q      <= crsdv_d;
            rxd_q        <= rxd_d;
            pre_cnt_q    <= pre_cnt_d;
            data_cnt_q   <= data_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            err_q        <= err_d;
            crc_q        <= crc_d;
            dline_q      <= dline_d;
            axi_valid_q  <= axi_valid_d;
            axi_dout_q   <= axi_dout_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
        end
    end

    assign axi_valid  = axi_valid_q;
    assign axi_dout   = axi_dout_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;

`ifdef MAC_RX_STATS_EN
    logic [15:0] stat_good_q, stat_good_d;
    logic [15:0] stat_bad_q, stat_bad_d;
    logic [15:0] stat_drop_q, stat_drop_d;
    logic        drop_entry;

    // Only drops decided before SFD are counted; an over-length abort is
    // already reported as a bad frame.
    assign drop_entry = (state_d == S_DROP) &&
                        ((state_q == S_IDLE) || (state_q == S_PREAMBLE));

    always_comb begin
        stat_good_d = stat_good_q;
        stat_bad_d  = stat_bad_q;
        stat_drop_d = stat_drop_q;
        if (frame_done_d && frame_ok_d && (stat_good_q != 16'hFFFF))
            stat_good_d = stat_good_q + 16'd1;
        if (frame_done_d && !frame_ok_d && (stat_bad_q != 16'hFFFF))
            stat_bad_d = stat_bad_q + 16'd1;
        if (drop_entry && (stat_drop_q != 16'hFFFF))
            stat_drop_d = stat_drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_good_q <= '0;
            stat_bad_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;
    assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx - directed self-checking bench for mac_rx.
// Inputs change on the falling edge; outputs are observed on the falling edge.

module tb_mac_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       phy_crsdv;
    logic [1:0] phy_rxd;
    logic       axi_valid;
    logic [1:0] axi_dout;
    logic       frame_done;
    logic       frame_ok;

    mac_rx dut (
        .clk        (clk),
        .reset      (reset),
        .phy_crsdv  (phy_crsdv),
        .phy_rxd    (phy_rxd),
        .axi_valid  (axi_valid),
        .axi_dout   (axi_dout),
        .frame_done (frame_done),
        .frame_ok   (frame_ok)
    );

    always #10 clk = ~clk;

    // Number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered on every falling edge.
    logic [1:0] axi_q[$];
    int         axi_cyc_q[$];
    logic       done_ok_q[$];
    int         done_cyc_q[$];
    int         overlap_cnt = 0;

    always @(negedge clk) begin
        if (axi_valid === 1'b1) begin
            axi_q.push_back(axi_dout);
            axi_cyc_q.push_back(cyc);
        end
        if (frame_done === 1'b1) begin
            done_ok_q.push_back(frame_ok);
            done_cyc_q.push_back(cyc);
        end
        if (axi_valid === 1'b1 && frame_done === 1'b1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame under construction and its expected payload.
    logic [1:0] tx_q[$];
    logic [1:0] pay_q[$];
    int         first_idx;
    int         mark_idx;
    int         first_pay_cyc;
    int         mark_cyc;
    int         fall_cyc;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 1; b >= 0; b--) begin
            if (r[31] ^ d[b]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // Preamble of npre x 01, SFD, payload i%4, FCS (one dibit optionally inverted).
    task automatic build_frame(input int npre, input int npay, input int bad_fcs);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [1:0]  dd;
        tx_q.delete();
        pay_q.delete();
        repeat (npre) tx_q.push_back(2'b01);
        tx_q.push_back(2'b11);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < npay; i++) begin
            dd = 2'(i % 4);
            pay_q.push_back(dd);
            tx_q.push_back(dd);
            crc = crc_dibit(crc, dd);
        end
        fcs = ~crc;
        for (int j = 0; j < 16; j++) begin
            dd = fcs[31-2*j -: 2];
            if (j == bad_fcs) dd = ~dd;
            tx_q.push_back(dd);
        end
        first_idx = npre + 1;
        mark_idx  = -1;
    endtask

    task automatic send(input logic dv, input logic [1:0] d);
        phy_crsdv = dv;
        phy_rxd   = d;
        @(negedge clk);
    endtask

    task automatic send_frame();
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == first_idx) first_pay_cyc = cyc;
            if (i == mark_idx)  mark_cyc = cyc;
            send(1'b1, tx_q[i]);
        end
        fall_cyc = cyc;
        send(1'b0, 2'b00);
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 2'b00);
    endtask

    task automatic clear_obs();
        axi_q.delete();
        axi_cyc_q.delete();
        done_ok_q.delete();
        done_cyc_q.delete();
    endtask

    // Emitted dibits against the expected payload, over the common prefix.
    task automatic check_stream(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < axi_q.size() && i < pay_q.size(); i++)
            if (axi_q[i] !== pay_q[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    // A complete good frame with 184 payload dibits, including timing.
    task automatic good_frame_checks(input string tag);
        build_frame(31, 184, -1);
        send_frame();
        idle(40);
        check({tag, " axi count"}, 32'(axi_q.size()), 32'd184);
        check_stream({tag, " payload"});
        check({tag, " done count"}, 32'(done_ok_q.size()), 32'd1);
        check({tag, " frame_ok"}, 32'(done_ok_q[0]), 32'd1);
        clear_obs();
    endtask

    initial begin
        reset     = 1'b1;
        phy_crsdv = 1'b0;
        phy_rxd   = 2'b00;
        repeat (3) @(negedge clk);
        check("reset axi_valid", 32'(axi_valid), 32'd0);
        check("reset axi_dout", 32'(axi_dout), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset frame_ok", 32'(frame_ok), 32'd0);
        reset = 1'b0;
        idle(5);

        // Good frame: 18 register stages from pin to axi_dout, status 17
        // cycles after the edge that samples the falling crsdv.
        build_frame(31, 184, -1);
        send_frame();
        idle(40);
        check("t1 axi count", 32'(axi_q.size()), 32'd184);
        check_stream("t1 payload");
        check("t1 first latency", 32'(axi_cyc_q[0] - first_pay_cyc), 32'd18);
        check("t1 done count", 32'(done_ok_q.size()), 32'd1);
        check("t1 frame_ok", 32'(done_ok_q[0]), 32'd1);
        check("t1 done latency", 32'(done_cyc_q[0] - (fall_cyc + 1)), 32'd17);
        clear_obs();

        // Corrupted FCS dibit 7: same payload, bad status.
        build_frame(31, 184, 7);
        send_frame();
        idle(40);
        check("t2 axi count", 32'(axi_q.size()), 32'd184);
        check_stream("t2 payload");
        check("t2 done count", 32'(done_ok_q.size()), 32'd1);
        check("t2 frame_ok", 32'(done_ok_q[0]), 32'd0);
        check("t2 done latency", 32'(done_cyc_q[0] - (fall_cyc + 1)), 32'd17);
        clear_obs();

        // Runt: 100 payload dibits with a valid FCS.
        build_frame(31, 100, -1);
        send_frame();
        idle(40);
        check("t3 axi count", 32'(axi_q.size()), 32'd100);
        check_stream("t3 payload");
        check("t3 done count", 32'(done_ok_q.size()), 32'd1);
        check("t3 frame_ok", 32'(done_ok_q[0]), 32'd0);
        clear_obs();

        // Short preamble is dropped silently; a good frame follows.
        build_frame(4, 20, -1);
        send_frame();
        idle(48);
        check("t4 drop axi count", 32'(axi_q.size()), 32'd0);
        check("t4 drop done count", 32'(done_ok_q.size()), 32'd0);
        clear_obs();
        good_frame_checks("t4 follow");

        // Over-length: abort when dibit 6073 is processed, then silence.
        build_frame(8, 6100, -1);
        mark_idx = first_idx + 6072;
        send_frame();
        idle(40);
        check("t5 done count", 32'(done_ok_q.size()), 32'd1);
        check("t5 frame_ok", 32'(done_ok_q[0]), 32'd0);
        check("t5 done timing", 32'(done_cyc_q[0] - mark_cyc), 32'd2);
        check("t5 no axi after abort", 32'(axi_cyc_q[axi_cyc_q.size()-1] < done_cyc_q[0]), 32'd1);
        check_stream("t5 payload prefix");
        clear_obs();

        // Reset in the middle of a frame, at payload dibit 50.
        build_frame(31, 184, -1);
        for (int i = 0; i < first_idx + 49; i++) send(1'b1, tx_q[i]);
        check("t6 axi_valid before reset", 32'(axi_valid), 32'd1);
        reset = 1'b1;
        send(1'b1, tx_q[first_idx + 49]);
        check("t6 reset axi_valid", 32'(axi_valid), 32'd0);
        check("t6 reset axi_dout", 32'(axi_dout), 32'd0);
        check("t6 reset frame_done", 32'(frame_done), 32'd0);
        check("t6 reset frame_ok", 32'(frame_ok), 32'd0);
        send(1'b0, 2'b00);
        reset = 1'b0;
        idle(30);
        check("t6 no done after reset", 32'(done_ok_q.size()), 32'd0);
        clear_obs();
        good_frame_checks("t6 follow");

        check("valid with done overlap", 32'(overlap_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_rx.md
Name: mac_rx

Overview:
RMII receive MAC, the counterpart of the transmit MAC. Samples 2-bit RMII dibits and strips the preamble/SFD. Streams payload dibits out on a valid-only stream, with the trailing 16 FCS dibits held back in a delay line. Checks the CRC-32 (same dibit ordering and crc32_bzip2 unit as the transmitter) and reports per-frame status to the downstream packet parser.

Parameters:
MIN_PREAMBLE_DIBITS, 8, minimum 2'b01 dibits before SFD for a valid preamble
MIN_DATA_DIBITS, 184, minimum payload dibits (excluding FCS); fewer = runt
MAX_FRAME_DIBITS, 6072, payload+FCS dibit ceiling; exceeding aborts the frame
CRC_DIBITS, 16, FCS length in dibits (fixed by protocol)

Ports:
clk  input  1  system clock (50 MHz RMII reference)
reset  input  1  synchronous, active-high reset
phy_crsdv  input  1  RMII carrier sense / data valid
phy_rxd  input  2  RMII receive dibit
axi_valid  output  1  axi_dout holds a payload dibit this cycle (no backpressure)
axi_dout  output  2  payload dibit, wire order
frame_done  output  1  one-cycle pulse at end of every frame that passed SFD
frame_ok  output  1  valid only with frame_done: 1 = CRC match, length in range, dibit count multiple of 4

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; delay line count 0. Reset mid-frame discards the frame, with no frame_done.
- Input stage: phy_crsdv/phy_rxd are registered once; all decisions use the registered copies.
- IDLE: crsdv=1 with rxd=01 -> PREAMBLE, preamble count=1. crsdv=1 with any other rxd -> DROP.
- PREAMBLE:
  - rxd=01: count++, saturating.
  - rxd=11 with count>=MIN_PREAMBLE_DIBITS: -> DATA. CRC init is asserted this cycle; data count=0.
  - rxd=11 with count too low, or rxd=00/10: -> DROP.
  - crsdv=0: -> IDLE, no frame_done.
- DATA, each cycle with crsdv=1:
  - Dibit shifts into the 16-entry delay line; data count++.
  - Once the line holds 16 dibits, the dibit shifted out is driven on axi_dout with axi_valid=1 on the next cycle. It is also fed to CRC with calc=1, d_valid=1.
  - End-to-end latency from sampled phy_rxd to axi_dout = 18 cycles (input reg + 16 + output reg).
  - data count > MAX_FRAME_DIBITS: frame_done=1, frame_ok=0, -> DROP.
- DATA, crsdv=0: frame ended.
  - Data count < CRC_DIBITS: frame_done=1, frame_ok=0 next cycle, -> IDLE.
  - Otherwise -> CHECK; the delay-line contents are the FCS.
- CHECK (16 cycles):
  - Shift one delay-line dibit per cycle; it is not emitted, axi_valid=0.
  - Drive CRC with calc=0, d_valid=1; compare the shifted dibit to the CRC stepwise output.
  - Any mismatch sets a sticky error flag.
  - After the 16th compare, the next cycle gives frame_done=1. frame_ok = no mismatch AND (count-16)>=MIN_DATA_DIBITS AND count[1:0]==0. Then -> IDLE.
- DROP: axi_valid=0; stay until registered crsdv=0, then -> IDLE. No frame_done unless it was issued on entry.
- crsdv=1 during CHECK: ignored. If still high on return to IDLE, the IDLE rules apply; a non-01 dibit -> DROP.
- axi_valid is never 1 in the same cycle as frame_done. Payload dibits of a failed frame are already emitted, so the consumer discards on frame_ok=0.

Optional Feature:
MAC_RX_STATS_EN
- Defined:
  - Adds outputs stat_good[15:0], stat_bad[15:0] and stat_drop[15:0].
  - stat_good / stat_bad count frame_done with frame_ok=1 / 0.
  - stat_drop counts entries into DROP from IDLE/PREAMBLE.
  - All three saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Frame: 31x01, 11, 184 payload dibits 0..183 mod 4, correct 16 FCS dibits, crsdv low -> 184 axi_valid cycles, first dibit 18 cycles after SFD+1, in order; frame_done=1, frame_ok=1 exactly 17 cycles after crsdv falls.
- Same frame with FCS dibit 7 inverted -> identical payload stream; frame_done=1, frame_ok=0.
- 100 payload dibits + valid FCS -> frame_done=1, frame_ok=0 (runt).
- Preamble of 4x01 then 11 -> DROP, no axi_valid, no frame_done; a correct frame following after a 48-cycle gap -> frame_ok=1.
- crsdv held high for 6100 dibits after SFD -> frame_done=1, frame_ok=0 at dibit 6073; no further axi_valid until crsdv low and a new preamble.
- Reset asserted at payload dibit 50 -> all outputs 0 the next cycle, no frame_done; the next full frame is received with frame_ok=1.
